serial_to_parallel: RTL and testbench
=====================================

# serial_to_parallel

Receive-side companion of the parallel-to-serial converter: rebuilds N-bit words from a serial bit stream sent LSB first, one bit per clock. A frame-start strobe marks bit 0 of each frame. Completed words are held in an output register with a valid/read handshake toward the consumer, and a sticky overrun flag is raised if a word is overwritten before it is read. Sits between the serial link and the parallel datapath, in the same clock domain as the transmitter.

## Interface
- N, default 8: word width in bits; N ≥ 2. Counter width is $clog2(N).

- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- data_in  input  1  serial data, bit 0 (LSB) first
- start_tick  input  1  high during the cycle that carries bit 0 of a frame
- read_en  input  1  consumer acknowledges data_out; honoured only while valid = 1
- data_out  output  N  last completed word (registered)
- valid  output  1  data_out holds an unread word
- done_tick  output  1  one-cycle pulse per completed word
- overrun  output  1  sticky: an unread word was overwritten

## Operation
- Reset (reset = 0, asynchronous):
  - state = IDLE, shift register = 0, count = 0
  - data_out = 0, valid = 0, done_tick = 0, overrun = 0
- Ports outside reset: data_in, start_tick and read_en are synchronous; no internal synchronisers.
- IDLE:
  - start_tick = 0: data_in is ignored.
  - start_tick = 1: data_in is captured as bit 0, count becomes 1, state goes to RECV.
- RECV:
  - Each edge captures data_in into bit position count, then count increments.
  - At count = N-1 the edge captures the last bit and completes the word: the full N-bit word goes to data_out, done_tick is set for the following cycle, count becomes 0, state returns to IDLE.
- Resync: start_tick = 1 while in RECV discards the partial word. That edge captures bit 0 of a new frame, count becomes 1, state stays RECV, and no done_tick is produced.
- start_tick on the completing edge itself (count = N-1) is ignored. A new frame needs start_tick in a later cycle.
- Back-to-back frames: start_tick may arrive on the cycle right after completion; no idle gap is required.
- Handshake:
  - valid is set on a completion edge.
  - valid clears on an edge where read_en = 1, valid = 1 and no completion occurs.
  - Completion and read_en on the same edge: the new word loads, valid stays 1, overrun is unchanged.
- Overrun:
  - Completion while valid = 1 and read_en = 0: data_out is overwritten with the new word and overrun is set.
  - overrun clears on an accepted read (read_en = 1, valid = 1) with no simultaneous overrun event.
  - Otherwise overrun holds until reset.
- read_en while valid = 0: no effect.

## Timing
- Edge numbering: edge 0 is the edge with start_tick = 1; bit k is sampled at edge k.
- data_out, valid and done_tick are updated at edge N-1 and visible in the cycle after it. Latency is N edges from start_tick to valid data.
- done_tick is high for exactly one cycle per completed word.
- Maximum throughput is one word per N cycles.
- Reset deassertion is synchronous to clk (handled at system level). The first edge after release may already accept start_tick.
- Reset mid-frame: the partial word is lost and there is no done_tick. The next start_tick begins a clean frame.

## Test plan
- Reset: drive reset = 0 with random inputs → data_out = 0, valid = 0, done_tick = 0, overrun = 0. After release, toggling data_in with start_tick = 0 produces no done_tick.
- Single frame, N = 8: 0xA5 LSB first (bits 1,0,1,0,0,1,0,1) with start_tick on bit 0 → after edge 7, data_out = 0xA5, valid = 1, done_tick high for exactly 1 cycle. A read_en pulse then clears valid.
- Back-to-back: frame 0x3C, start_tick on the very next cycle for frame 0xC3, read_en pulsed after each done_tick → words 0x3C then 0xC3, two done_ticks 8 cycles apart, overrun = 0.
- Resync: start_tick, 3 bits of garbage, start_tick again, then full 0x81 → exactly one done_tick, data_out = 0x81.
- Overrun and simultaneous read:
  - Frames 0x11 and 0x22 with no read_en → data_out = 0x22, valid = 1, overrun = 1. read_en → valid = 0, overrun = 0.
  - Repeat with read_en on the completion edge of 0x22 → valid = 1, overrun = 0.
- Reset mid-frame: assert reset after 4 bits of 0xFF → all outputs 0 immediately. A following full frame 0x5A yields data_out = 0x5A with one done_tick.

Source files
------------

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel receiver: rebuilds N-bit words sent LSB first, one bit per
// clock, framed by start_tick, with a valid/read output register and sticky overrun.
module serial_to_parallel #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         data_in,
  input  logic         start_tick,
  input  logic         read_en,
  output logic [N-1:0] data_out,
  output logic         valid,
  output logic         done_tick,
  output logic         overrun,
  output logic         fsm_state
);

  localparam int CW = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t        state;
  logic [N-1:0]  shift;
  logic [CW-1:0] count;
  logic          complete;

  // Handshake: valid rises on every completed word and falls on the first edge
  // that sees read_en = 1 while valid = 1, unless a new word completes on that
  // same edge (the new word then replaces the old one and valid stays high).
  assign complete  = (state == RECV) && (count == CW'(N - 1));
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift     <= '0;
      count     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      done_tick <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done_tick <= 1'b0;

      case (state)
        IDLE: begin
          if (start_tick) begin
            shift <= {{(N - 1){1'b0}}, data_in};
            count <= CW'(1);
            state <= RECV;
          end
        end
        RECV: begin
          if (complete) begin
            // start_tick on the completing edge is deliberately ignored
            shift <= '0;
            count <= '0;
            state <= IDLE;
          end else if (start_tick) begin
            shift <= {{(N - 1){1'b0}}, data_in};
            count <= CW'(1);
          end else begin
            shift[count] <= data_in;
            count        <= count + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase

      if (complete) begin
        data_out  <= {data_in, shift[N-2:0]};
        done_tick <= 1'b1;
        valid     <= 1'b1;
        if (valid && !read_en) begin
          overrun <= 1'b1;
        end
      end else if (read_en && valid) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel (N = 8): reset, single and back-to-back
// frames, resync, overrun, simultaneous read and mid-frame reset.
module tb_serial_to_parallel;

  logic       clk;
  logic       reset;
  logic       data_in;
  logic       start_tick;
  logic       read_en;
  logic [7:0] data_out;
  logic       valid;
  logic       done_tick;
  logic       overrun;
  logic       fsm_state;

  int n_pass;
  int n_total;
  int done_cnt;
  int cyc;
  int last_done;
  int done_gap;
  int mark;

  serial_to_parallel #(.N(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .start_tick (start_tick),
    .read_en    (read_en),
    .data_out   (data_out),
    .valid      (valid),
    .done_tick  (done_tick),
    .overrun    (overrun),
    .fsm_state  (fsm_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // done_tick monitor, sampled on the falling edge
  initial begin
    done_cnt  = 0;
    cyc       = 0;
    last_done = 0;
    done_gap  = 0;
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (done_tick === 1'b1) begin
      done_cnt  = done_cnt + 1;
      done_gap  = cyc - last_done;
      last_done = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick(input logic d, input logic st, input logic rd);
    data_in    = d;
    start_tick = st;
    read_en    = rd;
    @(posedge clk);
    #1;
    data_in    = 1'b0;
    start_tick = 1'b0;
    read_en    = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] w, input logic rd_first,
                            input logic rd_last, input logic st_last);
    for (int i = 0; i < 8; i++) begin
      data_in    = w[i];
      start_tick = (i == 0) || ((i == 7) && st_last);
      read_en    = ((i == 0) && rd_first) || ((i == 7) && rd_last);
      @(posedge clk);
      #1;
    end
    data_in    = 1'b0;
    start_tick = 1'b0;
    read_en    = 1'b0;
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    reset      = 1'b0;
    data_in    = 1'b0;
    start_tick = 1'b0;
    read_en    = 1'b0;

    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      data_in    = 1'($urandom_range(0, 1));
      start_tick = 1'($urandom_range(0, 1));
      read_en    = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_done_tick", 32'(done_tick), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_state", 32'(fsm_state), 32'h0);
    data_in    = 1'b0;
    start_tick = 1'b0;
    read_en    = 1'b0;
    reset      = 1'b1;

    // data_in toggling without start_tick is ignored
    mark = done_cnt;
    for (int i = 0; i < 5; i++) tick(i[0], 1'b0, 1'b0);
    check("idle_no_done", 32'(done_cnt - mark), 32'd0);
    check("idle_valid", 32'(valid), 32'h0);
    check("idle_state", 32'(fsm_state), 32'h0);

    // single frame 0xA5
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    check("a5_data_out", 32'(data_out), 32'hA5);
    check("a5_valid", 32'(valid), 32'h1);
    check("a5_done_hi", 32'(done_tick), 32'h1);
    tick(1'b0, 1'b0, 1'b0);
    check("a5_done_lo", 32'(done_tick), 32'h0);
    check("a5_valid_hold", 32'(valid), 32'h1);
    tick(1'b0, 1'b0, 1'b1);
    check("a5_read_valid", 32'(valid), 32'h0);
    check("a5_read_data", 32'(data_out), 32'hA5);
    check("a5_overrun", 32'(overrun), 32'h0);

    // back-to-back 0x3C then 0xC3, read pulsed right after each done_tick
    mark = done_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check("b2b_first_data", 32'(data_out), 32'h3C);
    check("b2b_first_done", 32'(done_tick), 32'h1);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    check("b2b_second_data", 32'(data_out), 32'hC3);
    check("b2b_second_valid", 32'(valid), 32'h1);
    check("b2b_overrun", 32'(overrun), 32'h0);
    tick(1'b0, 1'b0, 1'b1);
    check("b2b_done_count", 32'(done_cnt - mark), 32'd2);
    check("b2b_done_gap", 32'(done_gap), 32'd8);
    check("b2b_read_valid", 32'(valid), 32'h0);

    // resync: three garbage bits, then full 0x81 with a stray start on its last bit
    mark = done_cnt;
    tick(1'b1, 1'b1, 1'b0);
    check("resync_state_recv", 32'(fsm_state), 32'h1);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    check("resync_data", 32'(data_out), 32'h81);
    check("resync_state_idle", 32'(fsm_state), 32'h0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    check("resync_done_count", 32'(done_cnt - mark), 32'd1);
    check("resync_read_valid", 32'(valid), 32'h0);

    // overrun: 0x11 then 0x22 unread
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0);
    check("ovr_data", 32'(data_out), 32'h22);
    check("ovr_valid", 32'(valid), 32'h1);
    check("ovr_flag", 32'(overrun), 32'h1);
    tick(1'b0, 1'b0, 1'b0);
    check("ovr_sticky", 32'(overrun), 32'h1);
    tick(1'b0, 1'b0, 1'b1);
    check("ovr_read_valid", 32'(valid), 32'h0);
    check("ovr_read_clear", 32'(overrun), 32'h0);
    tick(1'b0, 1'b0, 1'b1);
    check("ovr_idle_read", 32'(valid), 32'h0);

    // read on the completion edge of 0x22
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    check("simul_data", 32'(data_out), 32'h22);
    check("simul_valid", 32'(valid), 32'h1);
    check("simul_overrun", 32'(overrun), 32'h0);

    // reset mid-frame after four bits of 0xFF
    for (int i = 0; i < 4; i++) tick(1'b1, (i == 0), 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_data", 32'(data_out), 32'h00);
    check("mid_rst_valid", 32'(valid), 32'h0);
    check("mid_rst_state", 32'(fsm_state), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    mark = done_cnt;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    check("post_rst_data", 32'(data_out), 32'h5A);
    check("post_rst_valid", 32'(valid), 32'h1);
    tick(1'b0, 1'b0, 1'b0);
    check("post_rst_done_count", 32'(done_cnt - mark), 32'd1);
    check("post_rst_overrun", 32'(overrun), 32'h0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
